// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt sequencer; sole CP0 write-port driver: EPC, then Status, then PC redirect.
// Optional CP0_EXC_DSLOT_EN: honour in_dslot_i (EPC = pc-4, bd_o=1) for delay-slot instructions.
module cp0_exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
   parameter logic [4:0]  EPC_ADDR    = 5'd14,
   parameter logic [4:0]  STATUS_ADDR = 5'd12
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        exc_valid_i,
   input  logic        exc_int_ok_i,
   input  logic        exc_syscall_i,
   input  logic        exc_break_i,
   input  logic        exc_ri_i,
   input  logic        exc_ov_i,
   input  logic        exc_eret_i,
   input  logic [31:0] pc_i,
   input  logic        in_dslot_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   input  logic        mtc0_we_i,
   input  logic [4:0]  mtc0_addr_i,
   input  logic [31:0] mtc0_data_i,
   output logic        cp0_we_o,
   output logic [4:0]  cp0_waddr_o,
   output logic [31:0] cp0_wdata_o,
   output logic [4:0]  exc_code_o,
   output logic        bd_o,
   output logic        flush_o,
   output logic        busy_o,
   output logic        new_pc_valid_o,
   output logic [31:0] new_pc_o
);

   typedef enum logic [1:0] {IDLE, WR_EPC, WR_STAT, REDIR} state_t;

   state_t      state;
   logic [31:0] pc_q;
   logic [31:0] status_q;
   logic        eret_q;
   logic        int_req;
   logic        exc_req;
   logic        any_req;
   logic [4:0]  code;
   logic        bd_q;
   logic        dslot;
   logic [31:0] epc_val;

   assign int_req = exc_int_ok_i & status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
   assign exc_req = exc_valid_i & (int_req | exc_ri_i | exc_ov_i | exc_syscall_i | exc_break_i);
   assign any_req = exc_req | (exc_valid_i & exc_eret_i);

   always_comb begin
      code = 5'd9;
      if (int_req)            code = 5'd0;
      else if (exc_ri_i)      code = 5'd10;
      else if (exc_ov_i)      code = 5'd12;
      else if (exc_syscall_i) code = 5'd8;
   end

`ifdef CP0_EXC_DSLOT_EN
   assign dslot = in_dslot_i;
   assign bd_o  = bd_q;
`else
   logic unused_dslot;
   assign unused_dslot = in_dslot_i;
   assign dslot = 1'b0;
   assign bd_o  = 1'b0;
`endif

   logic unused_cause;
   assign unused_cause = &{1'b0, cause_i[31:16], cause_i[7:0]};

   // bd_q is loaded in the same edge as the state change, so WR_EPC sees the fresh flag.
   assign epc_val = bd_q ? (pc_q - 32'd4) : pc_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         pc_q       <= '0;
         status_q   <= '0;
         eret_q     <= 1'b0;
         bd_q       <= 1'b0;
         exc_code_o <= '0;
      end else begin
         case (state)
            IDLE: if (any_req) begin
               pc_q     <= pc_i;
               status_q <= status_i;
               eret_q   <= ~exc_req;
               if (exc_req) begin
                  exc_code_o <= code;
                  bd_q       <= dslot;
                  state      <= WR_EPC;
               end else begin
                  state <= WR_STAT;
               end
            end
            WR_EPC:  state <= WR_STAT;
            WR_STAT: state <= REDIR;
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs are forced low during reset so an interrupted write sequence never reaches CP0.
   always_comb begin
      cp0_we_o       = 1'b0;
      cp0_waddr_o    = '0;
      cp0_wdata_o    = '0;
      flush_o        = 1'b0;
      busy_o         = 1'b0;
      new_pc_valid_o = 1'b0;
      new_pc_o       = '0;
      if (resetn) begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  flush_o = 1'b1;
                  busy_o  = 1'b1;
               end else begin
                  cp0_we_o    = mtc0_we_i;
                  cp0_waddr_o = mtc0_addr_i;
                  cp0_wdata_o = mtc0_data_i;
               end
            end
            WR_EPC: begin
               busy_o      = 1'b1;
               cp0_we_o    = 1'b1;
               cp0_waddr_o = EPC_ADDR;
               cp0_wdata_o = epc_val;
            end
            WR_STAT: begin
               busy_o      = 1'b1;
               cp0_we_o    = 1'b1;
               cp0_waddr_o = STATUS_ADDR;
               cp0_wdata_o = eret_q ? (status_q & ~32'h2) : (status_q | 32'h2);
            end
            default: begin
               busy_o         = 1'b1;
               new_pc_valid_o = 1'b1;
               new_pc_o       = eret_q ? epc_i : EXC_VECTOR;
            end
         endcase
      end
   end

endmodule
